// File: rtl/router_port_buf.sv
// Purpose: router input port buffer; credit-gated FIFO feeding a registered downstream flit stage.
// Latency: a flit written at edge E into an empty FIFO with credit appears on valid_o/data_o after edge E+1.
// Backpressure: pops stall while no downstream credits remain; flits arriving at a full FIFO are dropped and flagged.
module router_port_buf #(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 4,
    parameter int CREDIT_INIT = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               valid_i,
    input  logic [DATA_W-1:0]                  data_i,
    output logic                               credit_o,
    output logic                               valid_o,
    output logic [DATA_W-1:0]                  data_o,
    input  logic                               credit_i,
    output logic [$clog2(DEPTH+1)-1:0]         count_o,
    output logic [$clog2(CREDIT_INIT+1)-1:0]   credits_o,
    output logic                               ovf_err_o,
    output logic                               credit_err_o
);

    localparam int CW  = $clog2(DEPTH + 1);
    localparam int PW  = $clog2(DEPTH);
    localparam int CRW = $clog2(CREDIT_INIT + 1);

    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
    localparam logic [CRW-1:0] CRED_MAX = CRW'(CREDIT_INIT);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PW-1:0]     wr_ptr_q,  wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q,  rd_ptr_d;
    logic [CW-1:0]     count_q,   count_d;
    logic [CRW-1:0]    credits_q, credits_d;
    logic              valid_q,   valid_d;
    logic              credit_q,  credit_d;
    logic [DATA_W-1:0] data_q,    data_d;
    logic              ovf_q,     ovf_d;
    logic              cerr_q,    cerr_d;

    logic              wr_en;
    logic              pop;

    // Next-state: full/empty decisions use pre-edge occupancy so a same-edge pop never frees room for a write.
    always_comb begin
        wr_en     = valid_i && (count_q != FULL_CNT);
        pop       = (count_q != '0) && (credits_q != '0);

        wr_ptr_d  = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;

        count_d   = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        credits_d = credits_q;
        cerr_d    = cerr_q;
        if (pop && !credit_i) begin
            credits_d = credits_q - CRW'(1);
        end else if (credit_i && !pop) begin
            // A returned credit beyond the downstream depth means the peer is confused; saturate and flag.
            if (credits_q == CRED_MAX) begin
                cerr_d = 1'b1;
            end else begin
                credits_d = credits_q + CRW'(1);
            end
        end

        ovf_d     = ovf_q | (valid_i && (count_q == FULL_CNT));

        valid_d   = pop;
        credit_d  = pop;
        data_d    = pop ? mem_q[rd_ptr_q] : data_q;
    end

    // Control and output state; reset discards buffered flits without returning credits for them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            credits_q <= CRED_MAX;
            valid_q   <= 1'b0;
            credit_q  <= 1'b0;
            data_q    <= '0;
            ovf_q     <= 1'b0;
            cerr_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            credits_q <= credits_d;
            valid_q   <= valid_d;
            credit_q  <= credit_d;
            data_q    <= data_d;
            ovf_q     <= ovf_d;
            cerr_q    <= cerr_d;
        end
    end

    // Payload storage; contents are don't-care until written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign credit_o     = credit_q;
    assign valid_o      = valid_q;
    assign data_o       = data_q;
    assign count_o      = count_q;
    assign credits_o    = credits_q;
    assign ovf_err_o    = ovf_q;
    assign credit_err_o = cerr_q;

endmodule

// File: tb/tb_router_port_buf.sv
// Bench for router_port_buf: two instances (CREDIT_INIT=2 and CREDIT_INIT=1) driven by directed vectors.
// Expected flits go into per-instance queues; negedge monitors pop and compare whenever valid_o is high.
// Occupancy, credit and error outputs are checked directly against hand-computed values.
module tb_router_port_buf;

    logic        clk = 1'b0;
    logic        reset;

    logic        valid_a, credit_in_a, credit_a, vout_a, ovf_a, cerr_a;
    logic [15:0] din_a, dout_a;
    logic [2:0]  count_a;
    logic [1:0]  credits_a;

    logic        valid_b, credit_in_b, credit_b, vout_b, ovf_b, cerr_b;
    logic [15:0] din_b, dout_b;
    logic [2:0]  count_b;
    logic [0:0]  credits_b;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] exp_a, exp_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    router_port_buf #(.DATA_W(16), .DEPTH(4), .CREDIT_INIT(2)) u_dut_a (
        .clk(clk), .reset(reset), .valid_i(valid_a), .data_i(din_a),
        .credit_o(credit_a), .valid_o(vout_a), .data_o(dout_a), .credit_i(credit_in_a),
        .count_o(count_a), .credits_o(credits_a), .ovf_err_o(ovf_a), .credit_err_o(cerr_a)
    );

    router_port_buf #(.DATA_W(16), .DEPTH(4), .CREDIT_INIT(1)) u_dut_b (
        .clk(clk), .reset(reset), .valid_i(valid_b), .data_i(din_b),
        .credit_o(credit_b), .valid_o(vout_b), .data_o(dout_b), .credit_i(credit_in_b),
        .count_o(count_b), .credits_o(credits_b), .ovf_err_o(ovf_b), .credit_err_o(cerr_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor for instance A
    always @(negedge clk) begin
        if (!reset) begin
            chk("a_credit_o_tracks_valid_o", credit_a, vout_a);
            if (vout_a) begin
                if (qa.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL a_unexpected_flit: got 0x%0h expected none", dout_a);
                end else begin
                    exp_a = qa.pop_front();
                    chk("a_data_o", dout_a, exp_a);
                end
            end
        end
    end

    // Monitor for instance B
    always @(negedge clk) begin
        if (!reset) begin
            chk("b_credit_o_tracks_valid_o", credit_b, vout_b);
            if (vout_b) begin
                if (qb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL b_unexpected_flit: got 0x%0h expected none", dout_b);
                end else begin
                    exp_b = qb.pop_front();
                    chk("b_data_o", dout_b, exp_b);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        valid_a     = 1'b0; din_a = '0; credit_in_a = 1'b0;
        valid_b     = 1'b0; din_b = '0; credit_in_b = 1'b0;

        // Reset state
        step();
        chk("rst_valid_o", vout_a, 0);
        chk("rst_credit_o", credit_a, 0);
        chk("rst_data_o", dout_a, 0);
        chk("rst_count_o", count_a, 0);
        chk("rst_credits_o", credits_a, 2);
        chk("rst_ovf_err", ovf_a, 0);
        chk("rst_credit_err", cerr_a, 0);
        chk("rst_b_credits_o", credits_b, 1);
        reset = 1'b0;

        // Single flit, two-edge latency
        valid_a = 1'b1; din_a = 16'hA5A5; qa.push_back(16'hA5A5);
        step();
        valid_a = 1'b0;
        chk("single_count_after_write", count_a, 1);
        chk("single_no_early_valid", vout_a, 0);
        step();
        chk("single_valid_o", vout_a, 1);
        chk("single_credits_o", credits_a, 1);
        chk("single_count_drained", count_a, 0);
        credit_in_a = 1'b1;
        step();
        credit_in_a = 1'b0;
        chk("single_credit_returned", credits_a, 2);

        // Five flits with no credits returned: two leave, three stall
        for (int i = 1; i <= 5; i++) begin
            valid_a = 1'b1; din_a = 16'(i); qa.push_back(16'(i));
            step();
        end
        valid_a = 1'b0;
        chk("stall_count_o", count_a, 3);
        chk("stall_credits_o", credits_a, 0);
        step();
        step();
        chk("stall_count_held", count_a, 3);
        chk("stall_no_valid", vout_a, 0);
        for (int k = 0; k < 3; k++) begin
            credit_in_a = 1'b1;
            step();
            credit_in_a = 1'b0;
            chk("stall_no_pop_on_credit_edge", vout_a, 0);
            step();
            chk("stall_pop_after_credit", vout_a, 1);
        end
        chk("stall_count_empty", count_a, 0);
        chk("stall_no_ovf", ovf_a, 0);
        credit_in_a = 1'b1;
        step();
        step();
        credit_in_a = 1'b0;
        chk("stall_credits_restored", credits_a, 2);

        // Continuous stream with a credit returned on every pop
        for (int i = 0; i < 6; i++) begin
            valid_a = 1'b1; din_a = 16'h0100 + 16'(i); qa.push_back(16'h0100 + 16'(i));
            credit_in_a = (i >= 2);
            step();
            if (i >= 1) begin
                chk("stream_valid_every_cycle", vout_a, 1);
                chk("stream_credits_steady", credits_a, 1);
            end
        end
        valid_a = 1'b0; credit_in_a = 1'b1;
        step();
        chk("stream_last_valid", vout_a, 1);
        chk("stream_pop_and_credit_same_edge", credits_a, 1);
        chk("stream_count_empty", count_a, 0);
        step();
        credit_in_a = 1'b0;
        chk("stream_credits_back", credits_a, 2);
        chk("stream_idle_after", vout_a, 0);

        // Credit overflow while idle at full credit
        credit_in_a = 1'b1;
        step();
        credit_in_a = 1'b0;
        chk("cerr_credits_saturate", credits_a, 2);
        chk("cerr_set", cerr_a, 1);
        step();
        step();
        chk("cerr_sticky", cerr_a, 1);

        // CREDIT_INIT=1 instance: fill and overflow
        qb.push_back(16'h0010);
        for (int i = 0; i < 6; i++) begin
            valid_b = 1'b1; din_b = 16'h0010 + 16'(i);
            step();
            if (i == 4) begin
                chk("b_no_ovf_before_full", ovf_b, 0);
                chk("b_count_full", count_b, 4);
            end
        end
        valid_b = 1'b0;
        chk("b_ovf_set", ovf_b, 1);
        chk("b_count_after_drop", count_b, 4);
        chk("b_credits_zero", credits_b, 0);
        credit_in_b = 1'b1;
        step();
        credit_in_b = 1'b0;
        chk("b_credit_back", credits_b, 1);
        // Full before the edge: this flit is dropped even though a pop happens on the same edge
        valid_b = 1'b1; din_b = 16'h0016; qb.push_back(16'h0011);
        step();
        valid_b = 1'b0;
        chk("b_drop_despite_pop", count_b, 3);
        chk("b_pop_same_edge", vout_b, 1);
        for (int k = 0; k < 3; k++) begin
            qb.push_back(16'h0012 + 16'(k));
            credit_in_b = 1'b1;
            step();
            credit_in_b = 1'b0;
            step();
            chk("b_drain_pop", vout_b, 1);
        end
        chk("b_drained", count_b, 0);
        chk("b_ovf_sticky", ovf_b, 1);

        // Reset mid-operation with three flits buffered
        for (int i = 0; i < 5; i++) begin
            valid_a = 1'b1; din_a = 16'h0200 + 16'(i);
            if (i < 2) qa.push_back(16'h0200 + 16'(i));
            step();
        end
        valid_a = 1'b0;
        chk("mid_count_before_reset", count_a, 3);
        #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid_o", vout_a, 0);
        chk("mid_rst_credit_o", credit_a, 0);
        chk("mid_rst_data_o", dout_a, 0);
        chk("mid_rst_count_o", count_a, 0);
        chk("mid_rst_credits_o", credits_a, 2);
        chk("mid_rst_ovf_err", ovf_a, 0);
        chk("mid_rst_credit_err", cerr_a, 0);
        chk("mid_rst_b_ovf_err", ovf_b, 0);
        step();
        step();
        chk("mid_rst_held_count", count_a, 0);
        chk("mid_rst_held_credit_o", credit_a, 0);
        #3;
        reset = 1'b0;
        valid_a = 1'b1; din_a = 16'h5A5A; qa.push_back(16'h5A5A);
        step();
        valid_a = 1'b0;
        chk("post_rst_accept", count_a, 1);
        chk("post_rst_no_early_valid", vout_a, 0);
        step();
        chk("post_rst_valid_o", vout_a, 1);
        chk("post_rst_credits_o", credits_a, 1);

        step();
        step();
        step();
        chk("a_all_expected_seen", qa.size(), 0);
        chk("b_all_expected_seen", qb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/router_port_buf.md
ROUTER_PORT_BUF -- requirements
Module: router_port_buf

Parameters
REQ-001 DATA_W, default 16, flit width in bits; SHALL be >= 1.
REQ-002 DEPTH, default 4, input FIFO entries; SHALL be a power of two >= 2.
REQ-003 CREDIT_INIT, default 4, downstream buffer depth and initial credit count; SHALL be >= 1.

Interface
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 valid_i  input  1  upstream flit valid; a flit is offered on every cycle it is high.
REQ-007 data_i  input  DATA_W  upstream flit payload.
REQ-008 credit_o  output  1  one-cycle pulse returning one credit upstream per flit leaving the FIFO.
REQ-009 valid_o  output  1  downstream flit valid, registered.
REQ-010 data_o  output  DATA_W  downstream flit payload, registered.
REQ-011 credit_i  input  1  one-cycle pulse from downstream returning one credit.
REQ-012 count_o  output  $clog2(DEPTH+1)  current FIFO occupancy.
REQ-013 credits_o  output  $clog2(CREDIT_INIT+1)  current downstream credit count.
REQ-014 ovf_err_o  output  1  sticky: flit arrived while FIFO full.
REQ-015 credit_err_o  output  1  sticky: credit_i arrived while credit count was CREDIT_INIT.

Function
REQ-016 Write: at a rising edge with valid_i=1 and count_o<DEPTH, data_i SHALL be written at the tail.
REQ-017 Full: the full check SHALL use pre-edge occupancy; valid_i=1 with count_o=DEPTH SHALL drop the flit and set ovf_err_o, even if a pop occurs on the same edge.
REQ-018 Pop: at a rising edge with count_o>0 and credits_o>0, the head SHALL be removed and loaded into data_o; valid_o=1 and credit_o=1 for exactly the following cycle.
REQ-019 No pop: valid_o and credit_o SHALL be 0 in the following cycle; data_o SHALL hold its last value.
REQ-020 Latency: a flit written at edge E into an empty FIFO with credits_o>0 SHALL appear on valid_o/data_o after edge E+1; no combinational path from valid_i to valid_o.
REQ-021 Throughput: with credits available and continuous valid_i, one flit per cycle SHALL pass through.
REQ-022 Ordering: flits SHALL leave in arrival order; read/write pointers SHALL wrap modulo DEPTH.
REQ-023 Simultaneous write and pop: count_o SHALL be unchanged.
REQ-024 Credit count: pop alone decrements by 1, credit_i alone increments by 1, both on the same edge leave it unchanged.
REQ-025 Credit overflow: credit_i=1 without pop while credits_o=CREDIT_INIT SHALL leave credits_o at CREDIT_INIT and set credit_err_o.
REQ-026 Empty: no pop SHALL occur when count_o=0, whatever credits_o is.
REQ-027 Zero credits: no pop SHALL occur when credits_o=0; the FIFO holds and fills; a credit_i at edge E SHALL permit a pop at edge E+1.
REQ-028 Error flags SHALL stay set until reset.

Reset
REQ-029 Asserting reset SHALL immediately force valid_o=0, credit_o=0, data_o=0, count_o=0, ovf_err_o=0, credit_err_o=0, credits_o=CREDIT_INIT, and both pointers to 0.
REQ-030 Reset mid-operation SHALL discard all buffered flits; no credit_o pulse SHALL be issued for them.
REQ-031 After reset deasserts, the first rising edge SHALL accept valid_i normally.

Verification (DATA_W=16, DEPTH=4, CREDIT_INIT=2 unless noted)
REQ-032 Single flit 0xA5A5 at edge 1 -> valid_o=1, data_o=0xA5A5, credit_o=1 in the cycle after edge 2; credits_o=1.
REQ-033 Five back-to-back flits 0x0001..0x0005, credit_i held 0 -> 0x0001 and 0x0002 emitted in order, then stall; count_o=3; then 3 credit_i pulses -> 0x0003..0x0005 emitted in order; no ovf_err_o.
REQ-034 CREDIT_INIT=1, credit_i held 0, six flits 0x0010..0x0015 -> 0x0010 leaves, 0x0011..0x0014 fill the FIFO, 0x0015 dropped; ovf_err_o=1; count_o=4.
REQ-035 Idle, credits_o=2, credit_i pulse -> credits_o stays 2, credit_err_o=1 and stays set.
REQ-036 Pop and credit_i on the same edge with credits_o=1 -> credits_o remains 1; a continuous stream sustains one flit per cycle.
REQ-037 Reset asserted mid-edge with 3 flits buffered -> outputs clear immediately, credits_o=2, no credit_o pulses, next flit passes with 2-edge latency.
